// File: rtl/freq_ratio_detect_if.sv
// Handshake bundle for the slow-clock period/ratio detector.
// master drives enable and the clock under test; slave reports results.
interface freq_ratio_detect_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic             clk_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output en, clk_in,
        input  period, high_time, period_valid, locked, timeout
    );

    modport slave (
        input  en, clk_in,
        output period, high_time, period_valid, locked, timeout
    );
endinterface

// File: rtl/freq_ratio_detect.sv
// Measures period/high time of an async slow clock in fast-clock cycles.
// FREQ_DET_TOL_EN: periods within +/-1 count as matching for lock.
module freq_ratio_detect #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    freq_ratio_detect_if.slave  bus
);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LW-1:0]    LC_MAX  = LW'(LOCK_COUNT);
    localparam logic [LW-1:0]    LC_ONE  = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_FIRST,
        S_MEASURE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sq_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hcnt;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high_time;
    logic                   r_period_valid;
    logic                   r_locked;
    logic                   r_timeout;
    logic [LW-1:0]          r_lock_cnt;
    logic                   r_have_prev;

    logic                   w_sq;
    logic                   w_rise;
    logic                   w_match;
    logic [CNT_W-1:0]       w_hinc;
    logic [LW-1:0]          w_lock_inc;

    assign w_sq   = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sq & ~r_sq_prev;
    assign w_hinc = {{(CNT_W-1){1'b0}}, w_sq};

    assign w_lock_inc = (r_lock_cnt == LC_MAX) ? LC_MAX
                                               : r_lock_cnt + LC_ONE;

`ifdef FREQ_DET_TOL_EN
    logic [CNT_W-1:0] w_diff;
    assign w_diff  = (r_cnt >= r_period) ? (r_cnt - r_period)
                                         : (r_period - r_cnt);
    assign w_match = (w_diff <= CNT_ONE);
`else
    assign w_match = (r_cnt == r_period);
`endif

    assign bus.period       = r_period;
    assign bus.high_time    = r_high_time;
    assign bus.period_valid = r_period_valid;
    assign bus.locked       = r_locked;
    assign bus.timeout      = r_timeout;

    // Synchronize clk_in and keep the previous synced value for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_sq_prev <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.clk_in};
            r_sq_prev <= w_sq;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: en=0 forces IDLE; counter saturation falls back to WAIT_FIRST.
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.en) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT_FIRST;
                end
                S_WAIT_FIRST: begin
                    if (w_rise) begin
                        w_state_nxt = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (!w_rise && (r_cnt == CNT_MAX)) begin
                        w_state_nxt = S_WAIT_FIRST;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Counting, period capture, lock tracking and timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt          <= '0;
            r_hcnt         <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_timeout      <= 1'b0;
            r_lock_cnt     <= '0;
            r_have_prev    <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (!bus.en) begin
                r_cnt       <= '0;
                r_hcnt      <= '0;
                r_lock_cnt  <= '0;
                r_locked    <= 1'b0;
                r_timeout   <= 1'b0;
                r_have_prev <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_cnt  <= '0;
                        r_hcnt <= '0;
                    end
                    S_WAIT_FIRST: begin
                        if (w_rise) begin
                            r_cnt  <= CNT_ONE;
                            r_hcnt <= CNT_ONE;
                        end
                    end
                    S_MEASURE: begin
                        if (w_rise) begin
                            r_period       <= r_cnt;
                            r_high_time    <= r_hcnt;
                            r_period_valid <= 1'b1;
                            r_timeout      <= 1'b0;
                            r_cnt          <= CNT_ONE;
                            r_hcnt         <= CNT_ONE;
                            r_have_prev    <= 1'b1;
                            if (r_have_prev && w_match) begin
                                r_lock_cnt <= w_lock_inc;
                                r_locked   <= (w_lock_inc == LC_MAX);
                            end else begin
                                r_lock_cnt <= '0;
                                r_locked   <= 1'b0;
                            end
                        end else if (r_cnt == CNT_MAX) begin
                            r_timeout   <= 1'b1;
                            r_locked    <= 1'b0;
                            r_lock_cnt  <= '0;
                            r_have_prev <= 1'b0;
                            r_cnt       <= '0;
                            r_hcnt      <= '0;
                        end else begin
                            r_cnt  <= r_cnt + CNT_ONE;
                            r_hcnt <= r_hcnt + w_hinc;
                        end
                    end
                    default: begin
                        r_cnt  <= '0;
                        r_hcnt <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_freq_ratio_detect.sv
// Self-checking bench for freq_ratio_detect.
// Waveforms are built as (high,low) cycle pairs; expectations come from them.
module tb_freq_ratio_detect;
    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int LOCK_COUNT  = 4;
    localparam int MAXC        = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    freq_ratio_detect_if #(.CNT_W(CNT_W)) bus ();

    freq_ratio_detect #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
        bit lk;
        bit to;
        int cyc;
    } cap_t;

    cap_t caps[$];
    cap_t exp_q[$];
    cap_t mon_r;
    int   wh[$];
    int   wl[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc++;

    // Record every result pulse with the status seen alongside it.
    always @(negedge clk) begin
        if (bus.period_valid === 1'b1) begin
            mon_r.p   = int'(bus.period);
            mon_r.h   = int'(bus.high_time);
            mon_r.lk  = bus.locked;
            mon_r.to  = bus.timeout;
            mon_r.cyc = cyc;
            caps.push_back(mon_r);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void add_seg(input int h, input int l, input int n);
        repeat (n) begin
            wh.push_back(h);
            wl.push_back(l);
        end
    endfunction

    function automatic bit per_match(input int a, input int b);
`ifdef FREQ_DET_TOL_EN
        return (a - b <= 1) && (b - a <= 1);
`else
        return a == b;
`endif
    endfunction

    // Reference: each pair is one captured period; locked once the run of
    // consecutive matching periods reaches LOCK_COUNT.
    function automatic void build_exp();
        int run;
        run = 0;
        exp_q.delete();
        foreach (wh[i]) begin
            cap_t e;
            e.p   = wh[i] + wl[i];
            e.h   = wh[i];
            if (i > 0)
                run = per_match(e.p, exp_q[i-1].p) ? run + 1 : 0;
            e.lk  = (run >= LOCK_COUNT);
            e.to  = 1'b0;
            e.cyc = 0;
            exp_q.push_back(e);
        end
    endfunction

    task automatic start_meas();
        bus.en     = 1'b0;
        bus.clk_in = 1'b0;
        tick(3);
        caps.delete();
        bus.en = 1'b1;
        tick(4);
    endtask

    // Play the pairs, then a closing rising edge so the last pair is captured.
    task automatic play(input int tail);
        foreach (wh[i]) begin
            bus.clk_in = 1'b1;
            tick(wh[i]);
            bus.clk_in = 1'b0;
            tick(wl[i]);
        end
        bus.clk_in = 1'b1;
        tick(tail);
        bus.clk_in = 1'b0;
        tick(6);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.clk_in = 1'b1;
        tick(6);
        n_chk++;
        if (bus.period !== '0)
            $display("FAIL rst_period: got %0d need 0", bus.period);
        else n_pass++;
        n_chk++;
        if (bus.high_time !== '0)
            $display("FAIL rst_high: got %0d need 0", bus.high_time);
        else n_pass++;
        n_chk++;
        if (bus.period_valid !== 1'b0)
            $display("FAIL rst_valid: got %b need 0", bus.period_valid);
        else n_pass++;
        n_chk++;
        if (bus.locked !== 1'b0)
            $display("FAIL rst_locked: got %b need 0", bus.locked);
        else n_pass++;
        n_chk++;
        if (bus.timeout !== 1'b0)
            $display("FAIL rst_timeout: got %b need 0", bus.timeout);
        else n_pass++;
        rst    = 1'b0;
        bus.en = 1'b0;
        tick(2);
    endtask

    // Fixed scenarios: steady /8, switch 8->12, duty 3/10, alternating 8/9.
    task automatic test_patterns();
        for (int s = 0; s < 4; s++) begin
            wh.delete();
            wl.delete();
            case (s)
                0: add_seg(4, 4, LOCK_COUNT + 3);
                1: begin
                    add_seg(4, 4, LOCK_COUNT + 2);
                    add_seg(6, 6, LOCK_COUNT + 2);
                end
                2: add_seg(3, 7, LOCK_COUNT + 2);
                default: begin
                    for (int k = 0; k < 5; k++) begin
                        add_seg(4, 4, 1);
                        add_seg(4, 5, 1);
                    end
                end
            endcase
            build_exp();
            start_meas();
            play(3);
            n_chk++;
            if (caps.size() != exp_q.size())
                $display("FAIL pat%0d_count: got %0d need %0d",
                         s, caps.size(), exp_q.size());
            else n_pass++;
            foreach (exp_q[i]) begin
                if (i < caps.size()) begin
                    n_chk++;
                    if (caps[i].p != exp_q[i].p || caps[i].h != exp_q[i].h ||
                        caps[i].lk != exp_q[i].lk || caps[i].to != exp_q[i].to)
                        $display("FAIL pat%0d_cap%0d: got p=%0d h=%0d lk=%0d to=%0d need p=%0d h=%0d lk=%0d to=0",
                                 s, i, caps[i].p, caps[i].h, caps[i].lk, caps[i].to,
                                 exp_q[i].p, exp_q[i].h, exp_q[i].lk);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int nseg;
            wh.delete();
            wl.delete();
            nseg = $urandom_range(2, 4);
            for (int g = 0; g < nseg; g++) begin
                int h;
                int l;
                h = $urandom_range(1, 12);
                l = $urandom_range(1, 12);
                add_seg(h, l, $urandom_range(1, 7));
                if ($urandom_range(0, 1) == 1)
                    add_seg(h, l + 1, $urandom_range(1, 3));
            end
            build_exp();
            start_meas();
            play($urandom_range(1, 4));
            n_chk++;
            if (caps.size() != exp_q.size())
                $display("FAIL rnd%0d_count: got %0d need %0d",
                         it, caps.size(), exp_q.size());
            else n_pass++;
            foreach (exp_q[i]) begin
                if (i < caps.size()) begin
                    n_chk++;
                    if (caps[i].p != exp_q[i].p || caps[i].h != exp_q[i].h ||
                        caps[i].lk != exp_q[i].lk || caps[i].to != exp_q[i].to)
                        $display("FAIL rnd%0d_cap%0d: got p=%0d h=%0d lk=%0d to=%0d need p=%0d h=%0d lk=%0d to=0",
                                 it, i, caps[i].p, caps[i].h, caps[i].lk, caps[i].to,
                                 exp_q[i].p, exp_q[i].h, exp_q[i].lk);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_timeout();
        int  t_last;
        int  t_to;
        bit  seen;
        int  ncap;
        wh.delete();
        wl.delete();
        add_seg(4, 4, LOCK_COUNT + 2);
        build_exp();
        start_meas();
        play(3);
        n_chk++;
        if (caps.size() != exp_q.size() || caps.size() == 0 ||
            caps[caps.size()-1].lk != 1'b1)
            $display("FAIL to_prelock: got %0d caps need %0d locked",
                     caps.size(), exp_q.size());
        else n_pass++;
        t_last = (caps.size() > 0) ? caps[caps.size()-1].cyc : 0;
        ncap   = caps.size();
        seen   = 1'b0;
        t_to   = 0;
        for (int k = 0; k < 2 * MAXC && !seen; k++) begin
            @(negedge clk);
            if (bus.timeout === 1'b1) begin
                seen = 1'b1;
                t_to = cyc;
            end
        end
        n_chk++;
        if (!seen)
            $display("FAIL to_seen: got timeout=0 need 1 within %0d cycles", 2 * MAXC);
        else n_pass++;
        n_chk++;
        if (t_to - t_last != MAXC)
            $display("FAIL to_delay: got %0d cycles need %0d", t_to - t_last, MAXC);
        else n_pass++;
        n_chk++;
        if (bus.locked !== 1'b0)
            $display("FAIL to_locked: got %b need 0", bus.locked);
        else n_pass++;
        n_chk++;
        if (caps.size() != ncap)
            $display("FAIL to_novalid: got %0d caps need %0d", caps.size(), ncap);
        else n_pass++;
        tick(5);
        n_chk++;
        if (bus.timeout !== 1'b1)
            $display("FAIL to_hold: got %b need 1", bus.timeout);
        else n_pass++;
        caps.delete();
        wh.delete();
        wl.delete();
        add_seg(5, 5, LOCK_COUNT + 2);
        build_exp();
        play(2);
        n_chk++;
        if (caps.size() != exp_q.size())
            $display("FAIL to_restart_count: got %0d need %0d",
                     caps.size(), exp_q.size());
        else n_pass++;
        foreach (exp_q[i]) begin
            if (i < caps.size()) begin
                n_chk++;
                if (caps[i].p != exp_q[i].p || caps[i].h != exp_q[i].h ||
                    caps[i].lk != exp_q[i].lk || caps[i].to != 1'b0)
                    $display("FAIL to_restart_cap%0d: got p=%0d h=%0d lk=%0d to=%0d need p=%0d h=%0d lk=%0d to=0",
                             i, caps[i].p, caps[i].h, caps[i].lk, caps[i].to,
                             exp_q[i].p, exp_q[i].h, exp_q[i].lk);
                else n_pass++;
            end
        end
    endtask

    task automatic test_en_rst_drop();
        wh.delete();
        wl.delete();
        add_seg(4, 4, LOCK_COUNT + 2);
        start_meas();
        play(3);
        bus.clk_in = 1'b1;
        tick(2);
        bus.en = 1'b0;
        tick(1);
        n_chk++;
        if (bus.locked !== 1'b0 || bus.timeout !== 1'b0 ||
            bus.period_valid !== 1'b0)
            $display("FAIL en_drop_status: got lk=%b to=%b v=%b need 0 0 0",
                     bus.locked, bus.timeout, bus.period_valid);
        else n_pass++;
        n_chk++;
        if (bus.period !== CNT_W'(8) || bus.high_time !== CNT_W'(4))
            $display("FAIL en_drop_keep: got p=%0d h=%0d need p=8 h=4",
                     bus.period, bus.high_time);
        else n_pass++;
        bus.clk_in = 1'b0;
        start_meas();
        bus.clk_in = 1'b1;
        tick(4);
        bus.clk_in = 1'b0;
        tick(10);
        n_chk++;
        if (caps.size() != 0)
            $display("FAIL en_first_edge: got %0d valids need 0", caps.size());
        else n_pass++;
        start_meas();
        play(3);
        bus.clk_in = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        n_chk++;
        if (bus.period !== '0 || bus.high_time !== '0 || bus.locked !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.period_valid !== 1'b0)
            $display("FAIL rst_mid: got p=%0d h=%0d lk=%b to=%b v=%b need all 0",
                     bus.period, bus.high_time, bus.locked, bus.timeout,
                     bus.period_valid);
        else n_pass++;
        rst        = 1'b0;
        bus.clk_in = 1'b0;
        tick(2);
    endtask

    initial begin
        bus.en     = 1'b0;
        bus.clk_in = 1'b0;
        test_reset();
        test_patterns();
        test_random();
        test_timeout();
        test_en_rst_drop();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
